// File: rtl/multiplexor_pkg.sv
// Shared datapath constants for the registered 2:1 select block.
package multiplexor_pkg;
   localparam int   WIDTH_DEFAULT = 32;
   localparam logic SEL_CERO      = 1'b0;
   localparam logic SEL_UNO       = 1'b1;
endpackage

// File: rtl/multiplexor_mux2_sel.sv
// Combinational 2:1 word selector; anything other than a clean SEL_UNO picks cero.
module mux2_sel
   import multiplexor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             zf,
   input  logic [WIDTH-1:0] cero,
   input  logic [WIDTH-1:0] uno,
   output logic [WIDTH-1:0] y,
   output logic             sel
);
   // if-form so an unknown select falls through to cero rather than merging bits
   always_comb begin
      y   = cero;
      sel = SEL_CERO;
      if (zf == SEL_UNO) begin
         y   = uno;
         sel = SEL_UNO;
      end
   end
endmodule

// File: rtl/multiplexor.sv
// Registered 2:1 select with a two-entry (output + skid) valid/ready buffer.
module multiplexor
   import multiplexor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ZF,
   input  logic [WIDTH-1:0] cero,
   input  logic [WIDTH-1:0] uno,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] salida,
   output logic             sel_q
);
   logic [WIDTH-1:0] mux_data;
   logic             mux_sel;
   logic [WIDTH-1:0] salida_q, salida_d, skid_data_q, skid_data_d;
   logic             out_valid_q, out_valid_d, sel_d;
   logic             skid_full_q, skid_full_d, skid_sel_q, skid_sel_d;
   logic             in_ready_q, in_ready_d;
   logic             accept, drain;

   mux2_sel #(.WIDTH(WIDTH)) u_sel (
      .zf   (ZF),
      .cero (cero),
      .uno  (uno),
      .y    (mux_data),
      .sel  (mux_sel)
   );

   assign accept = in_valid && in_ready_q;
   assign drain  = out_valid_q && out_ready;

   always_comb begin
      salida_d    = salida_q;
      sel_d       = sel_q;
      out_valid_d = out_valid_q;
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
      skid_full_d = skid_full_q;
      if (drain || !out_valid_q) begin
         // Output slot is free this edge: skid word has priority over a new beat
         if (skid_full_q) begin
            salida_d    = skid_data_q;
            sel_d       = skid_sel_q;
            out_valid_d = 1'b1;
            skid_full_d = 1'b0;
         end else if (accept) begin
            salida_d    = mux_data;
            sel_d       = mux_sel;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_data_d = mux_data;
         skid_sel_d  = mux_sel;
         skid_full_d = 1'b1;
      end
      in_ready_d = !skid_full_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         salida_q    <= '0;
         sel_q       <= SEL_CERO;
         out_valid_q <= 1'b0;
         skid_data_q <= '0;
         skid_sel_q  <= SEL_CERO;
         skid_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         salida_q    <= salida_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
         skid_data_q <= skid_data_d;
         skid_sel_q  <= skid_sel_d;
         skid_full_q <= skid_full_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign salida    = salida_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
endmodule

// File: tb/tb_multiplexor.sv
// Self-checking bench: directed vector table, skid/reset sequences, random scoreboard run.
module tb_multiplexor;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, ZF, out_valid, out_ready, sel_q;
   logic [31:0] cero, uno, salida;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        zf;
      logic [31:0] cero;
      logic [31:0] uno;
      logic [31:0] exp_data;
      logic        exp_sel;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        sel;
   } beat_t;

   vec_t  vecs[4];
   beat_t sb[$];

   multiplexor #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ZF        (ZF),
      .cero      (cero),
      .uno       (uno),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .salida    (salida),
      .sel_q     (sel_q)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic offer(input logic zf, input logic [31:0] c, input logic [31:0] u);
      in_valid = 1'b1;
      ZF       = zf;
      cero     = c;
      uno      = u;
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0};
      vecs[1] = '{1'b1, 32'h00000001, 32'h00000002, 32'h00000002, 1'b1};
      vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1};
      vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ZF = 1'b0; cero = '0; uno = '0;
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_salida", salida, 32'd0);
      chk("rst_sel", {31'd0, sel_q}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

      // Directed select vectors, one beat each through an empty buffer
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer(vecs[i].zf, vecs[i].cero, vecs[i].uno);
         tick();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_salida", i), salida, vecs[i].exp_data);
         chk($sformatf("vec%0d_sel", i), {31'd0, sel_q}, {31'd0, vecs[i].exp_sel});
         chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         tick();
         chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
      end

      // Backpressure: A held, B in skid, C refused until space opens
      out_ready = 1'b0;
      offer(1'b0, 32'hAAAA0001, 32'h0);
      tick();
      chk("skid_A_out", salida, 32'hAAAA0001);
      chk("skid_rdy_after_A", {31'd0, in_ready}, 32'd1);
      offer(1'b1, 32'h0, 32'hBBBB0002);
      tick();
      chk("skid_rdy_after_B", {31'd0, in_ready}, 32'd0);
      chk("skid_A_hold", salida, 32'hAAAA0001);
      offer(1'b0, 32'hCCCC0003, 32'h0);
      tick();
      chk("skid_A_hold2", salida, 32'hAAAA0001);
      chk("skid_rdy_C", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("skid_B_out", salida, 32'hBBBB0002);
      chk("skid_B_sel", {31'd0, sel_q}, 32'd1);
      chk("skid_rdy_rise", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("skid_C_out", salida, 32'hCCCC0003);
      chk("skid_C_valid", {31'd0, out_valid}, 32'd1);
      tick();
      chk("skid_empty", {31'd0, out_valid}, 32'd0);

      // Reset with both stages full must discard everything
      out_ready = 1'b0;
      offer(1'b0, 32'hDDDD0004, 32'h0);
      tick();
      offer(1'b1, 32'h0, 32'hEEEE0005);
      tick();
      in_valid = 1'b0;
      chk("full_rdy", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      tick();
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_salida", salida, 32'd0);
      chk("midrst_rdy", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("midrst_rdy_next", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
         tick();
      end

      // Random traffic vs. an in-order queue of expected words
      for (int cyc = 0; cyc < 10000; cyc++) begin
         chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
         chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
         if (out_valid && sb.size() > 0) begin
            chk("rnd_salida", salida, sb[0].data);
            chk("rnd_sel", {31'd0, sel_q}, {31'd0, sb[0].sel});
         end
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 55);
         ZF        = $urandom_range(0, 1) == 1;
         cero      = $urandom;
         uno       = $urandom;
         if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
         if (in_valid && in_ready) sb.push_back('{ZF ? uno : cero, ZF});
         tick();
      end
      in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multiplexor.md
MULTIPLEXOR -- requirements
Module: multiplexor

Interface
REQ-001 Parameter WIDTH, default 32, data width of cero, uno, salida.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  producer presents ZF/cero/uno this cycle.
REQ-005 in_ready  output  1  block can accept an input beat this cycle.
REQ-006 ZF  input  1  zero flag select; 0 selects cero, 1 selects uno.
REQ-007 cero  input  WIDTH  data selected when ZF=0.
REQ-008 uno  input  WIDTH  data selected when ZF=1.
REQ-009 out_valid  output  1  salida holds a valid selected word.
REQ-010 out_ready  input  1  consumer accepts salida this cycle.
REQ-011 salida  output  WIDTH  selected data word, registered.
REQ-012 sel_q  output  1  ZF value that produced the current salida.

Function
REQ-013 Input beat accepted when in_valid && in_ready at a rising clk edge.
REQ-014 Accepted word = uno if ZF=1, else cero; full WIDTH bits, no modification or extension.
REQ-015 Latency: an accepted beat appears on salida/out_valid on the cycle after acceptance if the output register is empty or drains that same edge.
REQ-016 Output beat transfers when out_valid && out_ready at a rising edge.
REQ-017 While out_valid=1 and out_ready=0, salida and sel_q hold stable.
REQ-018 Two storage stages: output register plus one skid register; in_ready = NOT skid_full, registered, with no combinational path from out_ready.
REQ-019 Accept while output register is full and not draining: the beat goes to the skid register; in_ready drops next cycle.
REQ-020 Simultaneous accept and drain with skid empty: the new word loads the output register directly; out_valid stays 1.
REQ-021 Drain with skid full: the skid word moves to the output register; skid empties; in_ready rises next cycle.
REQ-022 Ordering is strict FIFO; no beat is dropped or duplicated.
REQ-023 ZF, cero, uno are ignored when in_valid=0 or in_ready=0.
REQ-024 Unknown ZF (X) selects cero in simulation; synthesis behaviour equals ZF=0.

Reset
REQ-025 While rst=1 at an edge: out_valid=0, salida=0, sel_q=0, skid empty, in_ready=0.
REQ-026 First edge with rst=0: in_ready=1; no output beat until a new input is accepted.
REQ-027 rst mid-operation discards both stored words; no stale word is emitted after reset.

Structure
REQ-028 Shared datapath package holds the WIDTH default (32) and the select encoding constants SEL_CERO=0, SEL_UNO=1.
REQ-029 One natural sub-module, mux2_sel: a purely combinational 2:1 WIDTH-bit selector instantiated once at the input.
REQ-030 The skid/output register control is a single flat always-block pair in multiplexor; no further hierarchy.

Verification
REQ-031 Reset, then ZF=0, cero=32'h00000001, uno=32'h00000002, in_valid=1, out_ready=1 -> next cycle salida=32'h00000001, sel_q=0, out_valid=1.
REQ-032 Same data, ZF=1 -> next cycle salida=32'h00000002, sel_q=1.
REQ-033 ZF=1, cero=32'hFFFFFFFF, uno=32'hFFFFFFFE -> salida=32'hFFFFFFFE; with ZF=0 -> 32'hFFFFFFFF.
REQ-034 out_ready=0, three back-to-back beats A, B, C offered -> A held on salida, B in skid, in_ready=0, C not accepted; raise out_ready -> A, B, then C emitted in order.
REQ-035 Assert rst for one cycle with both stages full -> out_valid=0, salida=0, in_ready=0 that cycle; in_ready=1 next; neither stored word ever emitted.
REQ-036 Random in_valid/out_ready for 10,000 cycles against a scoreboard model -> every output equals ZF?uno:cero of the matching accepted beat, in order.
